// File: rtl/randn_pool_loader.sv
// ============================================================================
// Module   : randn_pool_loader
// Brief    : Drains 32-bit pc_msg words into a byte pool and serves registered
//            byte reads once the pool is completely loaded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module randn_pool_loader #(
    parameter int DELAY      = 1,
    parameter int XB_SIZE    = 32,
    parameter int POOL_BYTES = 1024
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [XB_SIZE-1:0]                pc_msg,
    input  logic                              pc_msg_empty,
    output logic                              pc_msg_ack,
    input  logic                              reload,
    output logic                              pool_ready,
    output logic [$clog2(POOL_BYTES/4):0]     words_loaded,
    output logic [15:0]                       dropped,
    input  logic                              rd_en,
    input  logic [$clog2(POOL_BYTES)-1:0]     rd_addr,
    output logic [7:0]                        rd_data,
    output logic                              rd_valid
);

    localparam int WORDS = POOL_BYTES / 4;
    localparam int AW    = $clog2(POOL_BYTES);
    localparam int WAW   = AW - 2;
    localparam int WLW   = WAW + 1;
    localparam logic [WLW-1:0] LAST_WORD = WLW'(WORDS - 1);
    localparam logic [15:0]    DROP_MAX  = 16'hFFFF;

    // The word path is hard-wired to 32 bits; reject anything else at elaboration.
    if (XB_SIZE != 32 || POOL_BYTES < 8 || DELAY < 0) begin : g_param_check
        $error("randn_pool_loader: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WLW-1:0]     words_q, words_d;
    logic [15:0]        dropped_q, dropped_d;
    logic               ack;
    logic               wr_en;
    logic               rd_fire;

    logic [XB_SIZE-1:0] mem [WORDS];
    logic [XB_SIZE-1:0] rd_word_q;
    logic [1:0]         rd_sel_q;
    logic               rd_valid_q;
    logic [7:0]         rd_byte;

    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        dropped_d = dropped_q;
        ack       = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                words_d = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ack = !pc_msg_empty;
                if (ack) begin
                    wr_en   = 1'b1;
                    words_d = words_q + WLW'(1);
                    if (words_q == LAST_WORD) begin
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: begin
                // Keep draining so the host never stalls; those words are discarded.
                ack = !pc_msg_empty;
                if (ack && (dropped_q != DROP_MAX)) begin
                    dropped_d = dropped_q + 16'd1;
                end
                if (reload) begin
                    words_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            words_q   <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            words_q   <= words_d;
            dropped_q <= dropped_d;
        end
    end

    // Pool RAM: not reset, so a mid-load RESET leaves old contents in place.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[words_q[WAW-1:0]] <= pc_msg;
        end
    end

    assign rd_fire = rd_en && (state_q == ST_READY);

    always_ff @(posedge CLK) begin
        if (rd_fire) begin
            rd_word_q <= mem[rd_addr[AW-1:2]];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 2'd0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_sel_q <= rd_addr[1:0];
            end
        end
    end

    // Little-endian lane select: pool byte 4k+i lives in word k bits [8i+7:8i].
    always_comb begin
        rd_byte = 8'h00;
        case (rd_sel_q)
            2'd0:    rd_byte = rd_word_q[7:0];
            2'd1:    rd_byte = rd_word_q[15:8];
            2'd2:    rd_byte = rd_word_q[23:16];
            default: rd_byte = rd_word_q[31:24];
        endcase
    end

    assign pc_msg_ack   = ack;
    assign pool_ready   = (state_q == ST_READY);
    assign words_loaded = words_q;
    assign dropped      = dropped_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_valid_q ? rd_byte : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_randn_pool_loader.sv
// ============================================================================
// Module   : tb_randn_pool_loader
// Brief    : Directed self-checking bench for randn_pool_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_randn_pool_loader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] pc_msg;
    logic        pc_msg_empty;
    logic        pc_msg_ack;
    logic        reload;
    logic        pool_ready;
    logic [8:0]  words_loaded;
    logic [15:0] dropped;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;

    int n_checks = 0;
    int n_pass   = 0;

    randn_pool_loader #(
        .DELAY      (1),
        .XB_SIZE    (32),
        .POOL_BYTES (1024)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .pc_msg       (pc_msg),
        .pc_msg_empty (pc_msg_empty),
        .pc_msg_ack   (pc_msg_ack),
        .reload       (reload),
        .pool_ready   (pool_ready),
        .words_loaded (words_loaded),
        .dropped      (dropped),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Stream patterns: 0 ramp, 1 0xA5.., 2 0x11.., 3 0x22.., 4 0xDEADBEEF
    function automatic logic [31:0] word_of(input int mode, input int k);
        logic [31:0] w;
        w = 32'h0;
        case (mode)
            0: for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'((4*k + i) & 255);
            1: w = 32'hA5A5_A5A5;
            2: w = 32'h1111_1111;
            3: w = 32'h2222_2222;
            default: w = 32'hDEAD_BEEF;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input int a);
        case (mode)
            0:       return 8'(a & 255);
            1:       return 8'hA5;
            default: return 8'h11;
        endcase
    endfunction

    // Called and returns at posedge+1; one loop pass per clock cycle.
    task automatic load_words(input int n, input int mode, input bit gaps, input bit rd_always,
                              output int acks, output int cycles, output int ack_empty,
                              output int ready_seen, output int valid_seen);
        acks = 0; cycles = 0; ack_empty = 0; ready_seen = 0; valid_seen = 0;
        while (acks < n && cycles < 4000) begin
            pc_msg       = word_of(mode, acks);
            pc_msg_empty = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rd_always) begin
                rd_en   = 1'b1;
                rd_addr = 10'(cycles);
            end
            @(negedge CLK);
            if (pc_msg_ack && pc_msg_empty) ack_empty++;
            if (pool_ready) ready_seen++;
            if (rd_valid) valid_seen++;
            if (pc_msg_ack) acks++;
            cycles++;
            @(posedge CLK); #1;
        end
        pc_msg_empty = 1'b1;
    endtask

    task automatic rd_byte(input logic [9:0] a, output logic [7:0] d, output logic v);
        rd_en   = 1'b1;
        rd_addr = a;
        @(posedge CLK); #1;
        rd_en = 1'b0;
        @(negedge CLK);
        d = rd_data;
        v = rd_valid;
        @(posedge CLK); #1;
    endtask

    task automatic sweep(input string tag, input int mode);
        int bad;
        logic [7:0] d;
        logic v;
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            rd_byte(10'(a), d, v);
            if (v !== 1'b1 || d !== exp_byte(mode, a)) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int acks, cycles, ack_empty, ready_seen, valid_seen;
        logic [7:0] d;
        logic v;

        RESET = 1'b1; pc_msg = word_of(0, 0); pc_msg_empty = 1'b0;
        reload = 1'b0; rd_en = 1'b0; rd_addr = '0;

        // Reset: FIFO deliberately non-empty to prove ack is held low
        repeat (4) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rst_ack", pc_msg_ack, 0);
        check("rst_ready", pool_ready, 0);
        check("rst_words", words_loaded, 0);
        check("rst_dropped", dropped, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Full load, FIFO never empty: one IDLE cycle then 256 acks
        load_words(256, 0, 1'b0, 1'b0, acks, cycles, ack_empty, ready_seen, valid_seen);
        check("full_acks", acks, 256);
        check("full_cycles", cycles, 257);
        check("full_ready_early", ready_seen, 0);
        @(negedge CLK);
        check("full_ready", pool_ready, 1);
        check("full_words", words_loaded, 256);
        @(posedge CLK); #1;
        rd_byte(10'd5, d, v);
        check("rd5_valid", v, 1);
        check("rd5_data", d, 8'h05);
        @(negedge CLK);
        check("rd5_valid_drop", rd_valid, 0);
        @(posedge CLK); #1;

        // Overrun: 4 words in READY are popped and discarded
        load_words(4, 4, 1'b0, 1'b0, acks, cycles, ack_empty, ready_seen, valid_seen);
        check("ovr_acks", acks, 4);
        check("ovr_cycles", cycles, 4);
        check("ovr_dropped", dropped, 4);
        rd_byte(10'd0, d, v);    check("ovr_rd0", d, 8'h00);
        rd_byte(10'd5, d, v);    check("ovr_rd5", d, 8'h05);
        rd_byte(10'd1023, d, v); check("ovr_rd1023", d, 8'hFF);

        // Reload with a simultaneous read that must still complete
        reload = 1'b1; rd_en = 1'b1; rd_addr = 10'd7;
        @(posedge CLK); #1;
        reload = 1'b0; rd_en = 1'b0;
        @(negedge CLK);
        check("rel_rd_valid", rd_valid, 1);
        check("rel_rd_data", rd_data, 8'h07);
        check("rel_ready_low", pool_ready, 0);
        check("rel_words", words_loaded, 0);
        @(posedge CLK); #1;
        // IDLE cycle already consumed above, so only the 256 load cycles remain
        load_words(256, 1, 1'b0, 1'b0, acks, cycles, ack_empty, ready_seen, valid_seen);
        check("rel_acks", acks, 256);
        check("rel_cycles", cycles, 256);
        check("rel_ready_early", ready_seen, 0);
        @(negedge CLK);
        check("rel_ready", pool_ready, 1);
        check("rel_dropped", dropped, 4);
        @(posedge CLK); #1;
        sweep("rel_sweep_a5", 1);

        // Reset after 100 words of a new load
        reload = 1'b1;
        @(posedge CLK); #1;
        reload = 1'b0;
        load_words(100, 3, 1'b0, 1'b0, acks, cycles, ack_empty, ready_seen, valid_seen);
        check("mid_acks", acks, 100);
        check("mid_words", words_loaded, 100);
        RESET = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("mid_rst_words", words_loaded, 0);
        check("mid_rst_dropped", dropped, 0);
        check("mid_rst_ready", pool_ready, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        // Read gating: rd_en held high through the whole load
        load_words(256, 2, 1'b0, 1'b1, acks, cycles, ack_empty, ready_seen, valid_seen);
        check("mid_acks2", acks, 256);
        check("mid_cycles2", cycles, 257);
        check("mid_ready_early", ready_seen, 0);
        check("gate_valid_in_load", valid_seen, 0);
        rd_addr = 10'd600;
        @(negedge CLK);
        check("gate_no_valid_yet", rd_valid, 0);
        check("gate_ready", pool_ready, 1);
        @(posedge CLK); #1;
        rd_en = 1'b0;
        @(negedge CLK);
        check("gate_first_valid", rd_valid, 1);
        check("gate_rd600", rd_data, 8'h11);
        @(posedge CLK); #1;
        rd_byte(10'd601, d, v); check("w150_b1", d, 8'h11);
        rd_byte(10'd602, d, v); check("w150_b2", d, 8'h11);
        rd_byte(10'd603, d, v); check("w150_b3", d, 8'h11);

        // Gapped FIFO refill with the ramp pattern
        reload = 1'b1;
        @(posedge CLK); #1;
        reload = 1'b0;
        load_words(256, 0, 1'b1, 1'b0, acks, cycles, ack_empty, ready_seen, valid_seen);
        check("gap_acks", acks, 256);
        check("gap_ack_empty", ack_empty, 0);
        check("gap_ready_early", ready_seen, 0);
        @(negedge CLK);
        check("gap_ready", pool_ready, 1);
        check("gap_words", words_loaded, 256);
        @(posedge CLK); #1;
        sweep("gap_sweep_ramp", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
